// File: rtl/muldiv_ctrl.sv
`default_nettype none
//============================================================================
// Module   : muldiv_ctrl
// Purpose  : Sequencer for the shared multiply/divide resource. Accepts one
//            MULT or DIV request at a time, pulses the matching engine's
//            start, waits for its done and then issues a single HI/LO
//            write. Division by zero is trapped before launch, and an
//            engine that never completes is caught by a watchdog.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYCLES : maximum RUN-state cycles before a watchdog fault
//   CNT_W          : watchdog counter width, 2**CNT_W > TIMEOUT_CYCLES
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-low reset
//   req_valid    in   request strobe, sampled only in IDLE
//   req_op       in   0 = MULT, 1 = DIV
//   op_b         in   divisor, sampled with the request
//   flush        in   abort any operation, no HI/LO write
//   req_ready    out  high only in IDLE
//   busy         out  high in every state except IDLE
//   mult_start   out  one-cycle multiplier start pulse
//   mult_done    in   multiplier finished
//   div_start    out  one-cycle divider start pulse
//   div_done     in   divider finished
//   hilo_sel     out  HI/LO source select, 0 = mult, 1 = div
//   hi_w, lo_w   out  HI/LO register write enables
//   done         out  one-cycle completion pulse
//   div_zero     out  one-cycle divide-by-zero exception pulse
//   timeout      out  one-cycle watchdog fault pulse
//   op_count     out  (MULDIV_STATS_EN only) completed-operation count
// Build option
//   MULDIV_STATS_EN : when defined, adds the 16-bit op_count output that
//                     counts completed (written) operations, wrapping.
//============================================================================
module muldiv_ctrl #(
   parameter int TIMEOUT_CYCLES = 40,
   parameter int CNT_W          = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_op,
   input  logic [31:0] op_b,
   input  logic        flush,
   output logic        req_ready,
   output logic        busy,
   output logic        mult_start,
   input  logic        mult_done,
   output logic        div_start,
   input  logic        div_done,
   output logic        hilo_sel,
   output logic        hi_w,
   output logic        lo_w,
   output logic        done,
   output logic        div_zero,
   output logic        timeout
`ifdef MULDIV_STATS_EN
  ,output logic [15:0] op_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_MULT_RUN = 3'd1,
      S_DIV_RUN  = 3'd2,
      S_WRITE    = 3'd3,
      S_EXC      = 3'd4,
      S_FAULT    = 3'd5
   } state_t;

   // Last RUN cycle before the watchdog gives up.
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hilo_sel_q, hilo_sel_d;

   //-------------------------------------------------------------------------
   // State register
   //-------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         hilo_sel_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hilo_sel_q <= hilo_sel_d;
      end
   end

   //-------------------------------------------------------------------------
   // Next-state logic
   //-------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hilo_sel_d = hilo_sel_q;

      case (state_q)
         S_IDLE: begin
            // flush in IDLE suppresses acceptance for that cycle
            if (req_valid && !flush) begin
               if (!req_op) begin
                  state_d    = S_MULT_RUN;
                  cnt_d      = '0;
                  hilo_sel_d = 1'b0;
               end else if (op_b == 32'd0) begin
                  // trapped before launch; hilo_sel keeps its old value
                  state_d = S_EXC;
               end else begin
                  state_d    = S_DIV_RUN;
                  cnt_d      = '0;
                  hilo_sel_d = 1'b1;
               end
            end
         end

         S_MULT_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            // done is ignored in the start cycle (cnt==0); a done on the
            // final watchdog cycle still completes the operation
            if (flush)
               state_d = S_IDLE;
            else if (mult_done && (cnt_q != '0))
               state_d = S_WRITE;
            else if (cnt_q == C_CNT_LAST)
               state_d = S_FAULT;
         end

         S_DIV_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (flush)
               state_d = S_IDLE;
            else if (div_done && (cnt_q != '0))
               state_d = S_WRITE;
            else if (cnt_q == C_CNT_LAST)
               state_d = S_FAULT;
         end

         S_WRITE, S_EXC, S_FAULT: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   //-------------------------------------------------------------------------
   // Outputs: decoded purely from registered state
   //-------------------------------------------------------------------------
   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign mult_start = (state_q == S_MULT_RUN) && (cnt_q == '0);
   assign div_start  = (state_q == S_DIV_RUN)  && (cnt_q == '0);
   assign hilo_sel   = hilo_sel_q;
   assign hi_w       = (state_q == S_WRITE);
   assign lo_w       = (state_q == S_WRITE);
   assign done       = (state_q == S_WRITE);
   assign div_zero   = (state_q == S_EXC);
   assign timeout    = (state_q == S_FAULT);

`ifdef MULDIV_STATS_EN
   //-------------------------------------------------------------------------
   // Completed-operation counter; only WRITE cycles count, wraps naturally
   //-------------------------------------------------------------------------
   logic [15:0] op_count_q, op_count_d;

   always_comb begin
      op_count_d = op_count_q;
      if (state_q == S_WRITE)
         op_count_d = op_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset)
         op_count_q <= 16'd0;
      else
         op_count_q <= op_count_d;
   end

   assign op_count = op_count_q;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_muldiv_ctrl
// Purpose  : Directed self-checking bench for muldiv_ctrl. Outputs are
//            packed into one vector {req_ready, busy, mult_start,
//            div_start, hilo_sel, hi_w, lo_w, done, div_zero, timeout}
//            and compared against hand-computed codes each cycle.
// Revision : 1.0 - initial release
//============================================================================
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_op, flush, mult_done, div_done;
   logic [31:0] op_b;
   logic        req_ready, busy, mult_start, div_start, hilo_sel;
   logic        hi_w, lo_w, done, div_zero, timeout;
`ifdef MULDIV_STATS_EN
   logic [15:0] op_count;
`endif

   int checks   = 0;
   int failures = 0;

   // Expected output codes
   localparam logic [9:0] C_IDLE0   = 10'h200; // IDLE, hilo_sel=0
   localparam logic [9:0] C_IDLE1   = 10'h220; // IDLE, hilo_sel=1
   localparam logic [9:0] C_MSTART  = 10'h180; // MULT_RUN start cycle
   localparam logic [9:0] C_MRUN    = 10'h100; // MULT_RUN
   localparam logic [9:0] C_DSTART  = 10'h160; // DIV_RUN start cycle
   localparam logic [9:0] C_DRUN    = 10'h120; // DIV_RUN
   localparam logic [9:0] C_MWRITE  = 10'h11C; // WRITE, mult results
   localparam logic [9:0] C_DWRITE  = 10'h13C; // WRITE, div results
   localparam logic [9:0] C_EXC1    = 10'h122; // EXC, hilo_sel held at 1
   localparam logic [9:0] C_FAULT0  = 10'h101; // FAULT, hilo_sel=0

   muldiv_ctrl #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .op_b       (op_b),
      .flush      (flush),
      .req_ready  (req_ready),
      .busy       (busy),
      .mult_start (mult_start),
      .mult_done  (mult_done),
      .div_start  (div_start),
      .div_done   (div_done),
      .hilo_sel   (hilo_sel),
      .hi_w       (hi_w),
      .lo_w       (lo_w),
      .done       (done),
      .div_zero   (div_zero),
      .timeout    (timeout)
`ifdef MULDIV_STATS_EN
     ,.op_count   (op_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] outs();
      return {req_ready, busy, mult_start, div_start, hilo_sel,
              hi_w, lo_w, done, div_zero, timeout};
   endfunction

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Advance one cycle; sample point is 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge; afterwards we are in cycle T+1
   task automatic accept(input logic op, input logic [31:0] b);
      req_valid = 1'b1;
      req_op    = op;
      op_b      = b;
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_op = 1'b0; op_b = 32'd0;
      flush = 1'b0; mult_done = 1'b0; div_done = 1'b0;

      // Reset state
      step(); step();
      check("reset_outs", 16'(outs()), 16'(C_IDLE0));
`ifdef MULDIV_STATS_EN
      check("reset_opcount", op_count, 16'd0);
`endif
      reset = 1'b1;
      step();

      // MULT, done at T+5
      accept(1'b0, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         check($sformatf("mult_run_%0d", i), 16'(outs()),
               16'(i == 1 ? C_MSTART : C_MRUN));
         mult_done = (i == 5);
         step();
      end
      mult_done = 1'b0;
      check("mult_write", 16'(outs()), 16'(C_MWRITE));
      step();
      check("mult_ready", 16'(outs()), 16'(C_IDLE0));

      // DIV b=7, stray mult_done at T+10, div_done at T+33
      accept(1'b1, 32'd7);
      for (int i = 1; i <= 33; i++) begin
         check($sformatf("div_run_%0d", i), 16'(outs()),
               16'(i == 1 ? C_DSTART : C_DRUN));
         mult_done = (i == 10);
         div_done  = (i == 33);
         step();
      end
      mult_done = 1'b0; div_done = 1'b0;
      check("div_write", 16'(outs()), 16'(C_DWRITE));
      step();
      check("div_ready", 16'(outs()), 16'(C_IDLE1));

      // DIV by zero
      accept(1'b1, 32'd0);
      check("divzero_exc", 16'(outs()), 16'(C_EXC1));
      step();
      check("divzero_ready", 16'(outs()), 16'(C_IDLE1));

      // MULT with no done: watchdog
      accept(1'b0, 32'd0);
      for (int i = 1; i <= 40; i++) begin
         check($sformatf("wd_run_%0d", i), 16'(outs()),
               16'(i == 1 ? C_MSTART : C_MRUN));
         step();
      end
      check("wd_fault", 16'(outs()), 16'(C_FAULT0));
      step();
      check("wd_ready", 16'(outs()), 16'(C_IDLE0));

      // done on the last watchdog cycle wins
      accept(1'b0, 32'd0);
      for (int i = 1; i <= 40; i++) begin
         mult_done = (i == 40);
         step();
      end
      mult_done = 1'b0;
      check("edge_done_write", 16'(outs()), 16'(C_MWRITE));
      step();
      check("edge_done_ready", 16'(outs()), 16'(C_IDLE0));

      // flush together with div_done
      accept(1'b1, 32'd3);
      step(); step();
      check("flush_div_run", 16'(outs()), 16'(C_DRUN));
      flush = 1'b1; div_done = 1'b1;
      step();
      flush = 1'b0; div_done = 1'b0;
      check("flush_idle", 16'(outs()), 16'(C_IDLE1));
      step();
      check("flush_no_write", 16'(outs()), 16'(C_IDLE1));
`ifdef MULDIV_STATS_EN
      check("opcount_three", op_count, 16'd3);
`endif

      // reset during DIV_RUN
      accept(1'b1, 32'd5);
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("midop_reset", 16'(outs()), 16'(C_IDLE0));
`ifdef MULDIV_STATS_EN
      check("midop_reset_opcount", op_count, 16'd0);
`endif

      // flush in IDLE blocks acceptance
      req_valid = 1'b1; req_op = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      check("idle_flush_block", 16'(outs()), 16'(C_IDLE0));
      step();
      req_valid = 1'b0;
      check("accept_after_flush", 16'(outs()), 16'(C_MSTART));
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_mult", 16'(outs()), 16'(C_IDLE0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
